instr_fetch_unit: RTL and testbench

Upstream neighbour of the processor controller. Owns the program counter (PC) and the instruction register, and fetches 16-bit instructions from instruction memory through a request/valid handshake that tolerates wait states. It presents the latched instruction word on instr. The controller consumes instr and drives pc_clr, pc_inc, pc_ld, fetch_req and ir_ld back into this block.

---
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the program counter and the instruction register,
// and fetches instruction words from instruction memory through a
// request/valid handshake that tolerates any number of wait states.
// Optional feature macro: IFU_TIMEOUT_EN. When it is defined, a fetch that
// waits TIMEOUT_CYC cycles is abandoned and the sticky fetch_err flag is set.
// When it is not defined, WAIT may last indefinitely and fetch_err is tied 0.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef IFU_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_clr,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_ld_addr,
  input  logic              pc_inc,
  input  logic              fetch_req,
  input  logic              ir_ld,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [DATA_W-1:0]   instr_reg, instr_next;
  logic [DATA_W-1:0]   buf_reg, buf_next;
  logic [ADDR_W-1:0]   imem_addr_reg, imem_addr_next;
  logic                imem_rd_reg, imem_rd_next;
  logic                fetch_done_reg, fetch_done_next;

`ifdef IFU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                fetch_err_reg, fetch_err_next;
`endif

  // PC update: clear beats load beats increment; increment wraps naturally.
  always_comb begin
    pc_next = pc_reg;
    if (pc_clr) begin
      pc_next = RESET_PC;
    end else if (pc_ld) begin
      pc_next = pc_ld_addr;
    end else if (pc_inc) begin
      pc_next = pc_reg + ADDR_W'(1);
    end
  end

  // Fetch FSM next-state and registered-output logic.
  always_comb begin
    state_next      = state_reg;
    instr_next      = instr_reg;
    buf_next        = buf_reg;
    imem_addr_next  = imem_addr_reg;
    imem_rd_next    = imem_rd_reg;
    fetch_done_next = 1'b0;
`ifdef IFU_TIMEOUT_EN
    cnt_next        = cnt_reg;
    fetch_err_next  = fetch_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (fetch_req) begin
          // Address is the PC before any same-cycle PC update.
          imem_addr_next = pc_reg;
          imem_rd_next   = 1'b1;
          state_next     = WAIT;
`ifdef IFU_TIMEOUT_EN
          cnt_next       = '0;
`endif
        end
      end
      WAIT: begin
        if (imem_valid) begin
          imem_rd_next    = 1'b0;
          fetch_done_next = 1'b1;
          if (ir_ld) begin
            // Controller is already asking for the word: skip the buffer.
            instr_next = imem_rdata;
            state_next = IDLE;
          end else begin
            buf_next   = imem_rdata;
            state_next = READY;
          end
        end
`ifdef IFU_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          // This is the TIMEOUT_CYC-th empty WAIT cycle: give up.
          imem_rd_next   = 1'b0;
          fetch_err_next = 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
      end
      READY: begin
        if (ir_ld) begin
          instr_next = buf_reg;
          buf_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register for the FSM, PC, IR, buffer and memory interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      instr_reg      <= '0;
      buf_reg        <= '0;
      imem_addr_reg  <= '0;
      imem_rd_reg    <= 1'b0;
      fetch_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      buf_reg        <= buf_next;
      imem_addr_reg  <= imem_addr_next;
      imem_rd_reg    <= imem_rd_next;
      fetch_done_reg <= fetch_done_next;
    end
  end

`ifdef IFU_TIMEOUT_EN
  // Wait-state counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      fetch_err_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      fetch_err_reg <= fetch_err_next;
    end
  end

  assign fetch_err = fetch_err_reg;
`else
  assign fetch_err = 1'b0;
`endif

  assign pc         = pc_reg;
  assign instr      = instr_reg;
  assign imem_addr  = imem_addr_reg;
  assign imem_rd    = imem_rd_reg;
  assign fetch_done = fetch_done_reg;
  assign fetch_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed vectors, a transaction-level
// model checked against the DUT on every falling edge, and literal checks.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_clr, pc_ld, pc_inc, fetch_req, ir_ld, imem_valid;
  logic [7:0]  pc_ld_addr;
  logic [15:0] imem_rdata;
  logic [7:0]  imem_addr, pc;
  logic        imem_rd, fetch_busy, fetch_done, fetch_err;
  logic [15:0] instr;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_clr     (pc_clr),
    .pc_ld      (pc_ld),
    .pc_ld_addr (pc_ld_addr),
    .pc_inc     (pc_inc),
    .fetch_req  (fetch_req),
    .ir_ld      (ir_ld),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .pc         (pc),
    .instr      (instr),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- transaction-level model ----------------
  bit          model_live = 0;
  int          m_pc;
  logic [15:0] m_instr;
  int          m_addr;
  bit          m_outstanding;     // a memory read is in flight
  logic [15:0] m_words[$];        // fetched words waiting for ir_ld
  bit          m_done;
  bit          m_err;
  int          m_wait;            // empty wait cycles of the current read

  always @(posedge clk) begin
    if (rst) begin
      model_live    = 1;
      m_pc          = 0;
      m_instr       = '0;
      m_addr        = 0;
      m_outstanding = 0;
      m_words.delete();
      m_done        = 0;
      m_err         = 0;
      m_wait        = 0;
    end else if (model_live) begin
      m_done = 0;
      if (m_outstanding) begin
        if (imem_valid) begin
          m_done        = 1;
          m_outstanding = 0;
          if (ir_ld) m_instr = imem_rdata;
          else m_words.push_back(imem_rdata);
        end else begin
          m_wait = m_wait + 1;
`ifdef IFU_TIMEOUT_EN
          if (m_wait == 15) begin
            m_outstanding = 0;
            m_err         = 1;
          end
`endif
        end
      end else if (m_words.size() > 0) begin
        if (ir_ld) m_instr = m_words.pop_front();
      end else if (fetch_req) begin
        m_outstanding = 1;
        m_addr        = m_pc;
        m_wait        = 0;
      end
      if (pc_clr)      m_pc = 0;
      else if (pc_ld)  m_pc = int'(pc_ld_addr);
      else if (pc_inc) m_pc = (m_pc + 1) % 256;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("pc",         32'(pc),         32'(m_pc));
      chk("instr",      32'(instr),      32'(m_instr));
      chk("imem_addr",  32'(imem_addr),  32'(m_addr));
      chk("imem_rd",    32'(imem_rd),    32'(m_outstanding));
      chk("fetch_busy", 32'(fetch_busy), 32'(m_outstanding || (m_words.size() > 0)));
      chk("fetch_done", 32'(fetch_done), 32'(m_done));
      chk("fetch_err",  32'(fetch_err),  32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_clr = 0; pc_ld = 0; pc_inc = 0; fetch_req = 0; ir_ld = 0;
    imem_valid = 0; pc_ld_addr = '0; imem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    tick(2);
    rst = 0;
    $display("txn reset");
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_rd", 32'(imem_rd), 32'h0);
    chk("rst_busy", 32'(fetch_busy), 32'h0);

    // PC increments, then clear beats increment.
    pc_inc = 1; tick(3); pc_inc = 0;
    $display("txn pc_inc x3");
    chk("pc_inc3", 32'(pc), 32'h3);
    pc_clr = 1; pc_inc = 1; tick(1); pc_clr = 0; pc_inc = 0;
    $display("txn pc_clr+pc_inc");
    chk("pc_clr_wins", 32'(pc), 32'h0);

    // Normal fetch with one wait state, ir_ld one cycle after fetch_done.
    pc_ld = 1; pc_ld_addr = 8'h10; tick(1); pc_ld = 0;
    fetch_req = 1; tick(1); fetch_req = 0;
    chk("fetch_addr", 32'(imem_addr), 32'h10);
    chk("fetch_rd", 32'(imem_rd), 32'h1);
    tick(1);
    imem_valid = 1; imem_rdata = 16'h1234; tick(1); imem_valid = 0;
    chk("done_pulse", 32'(fetch_done), 32'h1);
    chk("ready_rd", 32'(imem_rd), 32'h0);
    tick(1);
    chk("done_single", 32'(fetch_done), 32'h0);
    chk("ready_busy", 32'(fetch_busy), 32'h1);
    ir_ld = 1; tick(1); ir_ld = 0;
    $display("txn fetch 0x10 -> 0x1234");
    chk("instr_1234", 32'(instr), 32'h1234);
    chk("idle_busy", 32'(fetch_busy), 32'h0);

    // Bypass: valid and ir_ld together in WAIT.
    fetch_req = 1; tick(1); fetch_req = 0;
    imem_valid = 1; ir_ld = 1; imem_rdata = 16'hA5F0; tick(1);
    imem_valid = 0; ir_ld = 0;
    $display("txn bypass 0xA5F0");
    chk("bypass_instr", 32'(instr), 32'hA5F0);
    chk("bypass_busy", 32'(fetch_busy), 32'h0);
    chk("bypass_done", 32'(fetch_done), 32'h1);
    tick(1);
    chk("bypass_done_off", 32'(fetch_done), 32'h0);

    // PC wrap and load-over-increment priority.
    pc_ld = 1; pc_ld_addr = 8'hFF; tick(1); pc_ld = 0;
    pc_inc = 1; tick(1); pc_inc = 0;
    $display("txn pc wrap");
    chk("pc_wrap", 32'(pc), 32'h0);
    pc_ld = 1; pc_ld_addr = 8'h42; pc_inc = 1; tick(1); pc_ld = 0; pc_inc = 0;
    $display("txn pc_ld over pc_inc");
    chk("pc_ld_wins", 32'(pc), 32'h42);

    // Reset in WAIT abandons the access; late valid ignored.
    fetch_req = 1; tick(1); fetch_req = 0;
    chk("pre_rst_rd", 32'(imem_rd), 32'h1);
    rst = 1; tick(1); rst = 0;
    imem_valid = 1; imem_rdata = 16'hBEEF; tick(1); imem_valid = 0;
    $display("txn reset during WAIT");
    chk("rst_wait_instr", 32'(instr), 32'h0);
    chk("rst_wait_rd", 32'(imem_rd), 32'h0);
    chk("rst_wait_done", 32'(fetch_done), 32'h0);
    tick(1);
    chk("rst_wait_done2", 32'(fetch_done), 32'h0);

    // Fetch address uses the pre-increment PC; fetch_req in READY ignored.
    pc_inc = 1; fetch_req = 1; tick(1); pc_inc = 0; fetch_req = 0;
    chk("addr_old_pc", 32'(imem_addr), 32'h0);
    chk("pc_after_inc", 32'(pc), 32'h1);
    imem_valid = 1; imem_rdata = 16'h0F0F; tick(1); imem_valid = 0;
    fetch_req = 1; tick(1); fetch_req = 0;
    chk("ready_req_ignored", 32'(imem_rd), 32'h0);
    ir_ld = 1; tick(1); ir_ld = 0;
    $display("txn fetch at old pc -> 0x0F0F");
    chk("instr_0f0f", 32'(instr), 32'h0F0F);

`ifdef IFU_TIMEOUT_EN
    // Timeout after 15 empty WAIT cycles; error stays sticky.
    fetch_req = 1; tick(1); fetch_req = 0;
    tick(14);
    chk("to_still_wait", 32'(imem_rd), 32'h1);
    tick(1);
    $display("txn timeout");
    chk("to_rd", 32'(imem_rd), 32'h0);
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_instr", 32'(instr), 32'h0F0F);
    fetch_req = 1; tick(1); fetch_req = 0;
    imem_valid = 1; imem_rdata = 16'h5A5A; ir_ld = 1; tick(1);
    imem_valid = 0; ir_ld = 0;
    $display("txn fetch after timeout");
    chk("after_to_instr", 32'(instr), 32'h5A5A);
    chk("after_to_err", 32'(fetch_err), 32'h1);
`else
    // Without the timeout a long WAIT persists and no error is raised.
    fetch_req = 1; tick(1); fetch_req = 0;
    tick(40);
    chk("long_wait_rd", 32'(imem_rd), 32'h1);
    chk("long_wait_err", 32'(fetch_err), 32'h0);
    imem_valid = 1; imem_rdata = 16'h5A5A; ir_ld = 1; tick(1);
    imem_valid = 0; ir_ld = 0;
    $display("txn long wait fetch");
    chk("long_wait_instr", 32'(instr), 32'h5A5A);
`endif

    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
